press_classifier: RTL and testbench

PRESS_CLASSIFIER -- requirements
Module: press_classifier

---
 rtl/press_pkg.sv | 16 +
 rtl/cycle_timer.sv | 22 ++
 rtl/press_classifier.sv | 114 +++++++++++
 tb/tb_press_classifier.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/press_pkg.sv
// Shared types and default timing constants for the button press classifier.
package press_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESS1    = 3'd1,
        LONG_HOLD = 3'd2,
        WAIT_GAP  = 3'd3,
        PRESS2    = 3'd4
    } state_t;

    localparam int unsigned LONG_T_DEFAULT = 50_000_000;
    localparam int unsigned GAP_T_DEFAULT  = 15_000_000;
    localparam int unsigned CW_DEFAULT     = 26;

endpackage

// File: rtl/cycle_timer.sv
// Up-counting cycle timer with synchronous clear; the owner gates enable so it never wraps.
module cycle_timer #(
    parameter int unsigned CW = 26
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          enable,
    output logic [CW-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/press_classifier.sv
// Classifies a debounced button level into short, long and double presses.
//
// state     | meaning
// ----------|-----------------------------------------------------------
// IDLE      | button released, nothing pending
// PRESS1    | first press in progress, timing hold length
// LONG_HOLD | long press already reported, waiting for release
// WAIT_GAP  | first press released, timing gap for a possible second press
// PRESS2    | second press in progress, reported as double on release
module press_classifier
    import press_pkg::*;
#(
    parameter int unsigned LONG_T = LONG_T_DEFAULT,
    parameter int unsigned GAP_T  = GAP_T_DEFAULT,
    parameter int unsigned CW     = CW_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in,
    output logic       short_press,
    output logic       long_press,
    output logic       double_press,
    output logic       held,
    output logic [7:0] press_count
);

    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_T - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_T - 1);

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] timer;
    logic          timer_clr;
    logic          timer_en;
    logic          short_nx;
    logic          long_nx;
    logic          double_nx;

    cycle_timer #(.CW(CW)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clr),
        .enable (timer_en),
        .count  (timer)
    );

    always_comb begin
        state_nx  = state;
        timer_clr = 1'b0;
        timer_en  = 1'b0;
        short_nx  = 1'b0;
        long_nx   = 1'b0;
        double_nx = 1'b0;
        case (state)
            IDLE: begin
                timer_clr = 1'b1;
                if (in) state_nx = PRESS1;
            end
            PRESS1: begin
                // release wins over reaching the long threshold on the same edge
                if (!in) begin
                    state_nx  = WAIT_GAP;
                    timer_clr = 1'b1;
                end else if (timer == LONG_LAST) begin
                    state_nx = LONG_HOLD;
                    long_nx  = 1'b1;
                end else begin
                    timer_en = 1'b1;
                end
            end
            LONG_HOLD: begin
                if (!in) state_nx = IDLE;
            end
            WAIT_GAP: begin
                if (in) begin
                    state_nx = PRESS2;
                end else if (timer == GAP_LAST) begin
                    state_nx = IDLE;
                    short_nx = 1'b1;
                end else begin
                    timer_en = 1'b1;
                end
            end
            PRESS2: begin
                if (!in) begin
                    state_nx  = IDLE;
                    double_nx = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            double_press <= 1'b0;
            held         <= 1'b0;
            press_count  <= 8'd0;
        end else begin
            state        <= state_nx;
            short_press  <= short_nx;
            long_press   <= long_nx;
            double_press <= double_nx;
            held         <= (state_nx == LONG_HOLD);
            if (short_nx || long_nx || double_nx) begin
                press_count <= press_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_press_classifier.sv
// Bench for press_classifier: run-length reference model over directed and random press patterns.
module tb_press_classifier;

    localparam int LONG_T = 8;
    localparam int GAP_T  = 4;
    localparam int MAXN   = 2048;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       din = 1'b0;
    logic       short_press;
    logic       long_press;
    logic       double_press;
    logic       held;
    logic [7:0] press_count;

    int vectors = 0;
    int miscompares = 0;
    int ptr = 0;

    bit         stim [MAXN];
    bit         es   [MAXN];
    bit         el   [MAXN];
    bit         ed   [MAXN];
    bit         eh   [MAXN];
    logic [7:0] ec   [MAXN];

    press_classifier #(.LONG_T(LONG_T), .GAP_T(GAP_T), .CW(8)) dut (
        .clk          (clk),
        .reset        (rst_n),
        .in           (din),
        .short_press  (short_press),
        .long_press   (long_press),
        .double_press (double_press),
        .held         (held),
        .press_count  (press_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic add(input bit v, input int len);
        for (int i = 0; i < len; i++) begin
            stim[ptr] = v;
            ptr++;
        end
    endtask

    function automatic int run_len(input int from, input bit v, input int n);
        int i;
        i = 0;
        while (from + i < n && stim[from + i] == v) i++;
        return i;
    endfunction

    // Expected outputs after each sampling edge, derived from press/gap run lengths.
    task automatic build_model(input int n);
        int e, s, h, r, g, q, h2, cnt;
        for (int k = 0; k < n; k++) begin
            es[k] = 1'b0; el[k] = 1'b0; ed[k] = 1'b0; eh[k] = 1'b0;
        end
        e = 0;
        while (e < n) begin
            if (!stim[e]) begin
                e++;
            end else begin
                s = e;
                h = run_len(s, 1'b1, n);
                if (h >= LONG_T + 1) begin
                    el[s + LONG_T] = 1'b1;
                    for (int k = s + LONG_T; k < s + h; k++) eh[k] = 1'b1;
                    e = s + h + 1;
                end else begin
                    r = s + h;
                    g = run_len(r, 1'b0, n);
                    if (g >= GAP_T + 1) begin
                        es[r + GAP_T] = 1'b1;
                        e = r + GAP_T + 1;
                    end else if (r + g >= n) begin
                        e = n;
                    end else begin
                        q  = r + g;
                        h2 = run_len(q, 1'b1, n);
                        if (q + h2 < n) ed[q + h2] = 1'b1;
                        e = q + h2 + 1;
                    end
                end
            end
        end
        cnt = 0;
        for (int k = 0; k < n; k++) begin
            cnt += int'(es[k]) + int'(el[k]) + int'(ed[k]);
            ec[k] = 8'(cnt);
        end
    endtask

    task automatic run_seg();
        int n;
        n = ptr;
        build_model(n);
        for (int k = 0; k < n; k++) begin
            din = stim[k];
            @(posedge clk);
            #1;
            check($sformatf("short@%0d", k),  short_press,  es[k]);
            check($sformatf("long@%0d", k),   long_press,   el[k]);
            check($sformatf("double@%0d", k), double_press, ed[k]);
            check($sformatf("held@%0d", k),   held,         eh[k]);
            check($sformatf("count@%0d", k),  press_count,  ec[k]);
        end
        ptr = 0;
    endtask

    task automatic outputs_zero(input string tag);
        check({tag, "_short"},  short_press,  8'd0);
        check({tag, "_long"},   long_press,   8'd0);
        check({tag, "_double"}, double_press, 8'd0);
        check({tag, "_held"},   held,         8'd0);
        check({tag, "_count"},  press_count,  8'd0);
    endtask

    task automatic do_reset(input bit lvl, input string tag);
        din   = lvl;
        rst_n = 1'b0;
        #1;
        outputs_zero({tag, "_async"});
        repeat (2) @(posedge clk);
        #1;
        outputs_zero({tag, "_hold"});
        rst_n = 1'b1;
    endtask

    initial begin
        int lim;
        int hi;
        int lo;

        // reset held with the button pressed, then the level counts as a new press
        do_reset(1'b1, "rst0");
        add(1'b1, 3); add(1'b0, 10);
        run_seg();
        check("short_total", press_count, 8'd1);

        do_reset(1'b0, "rst1");
        add(1'b1, 20); add(1'b0, 3);
        run_seg();
        check("long_total", press_count, 8'd1);

        do_reset(1'b0, "rst2");
        add(1'b1, 2); add(1'b0, 2); add(1'b1, 2); add(1'b0, 6);
        run_seg();
        check("double_total", press_count, 8'd1);

        // release on the last timer count, re-press on the last gap count, gap one too long
        do_reset(1'b0, "rst3");
        add(1'b1, LONG_T); add(1'b0, GAP_T + 2);
        add(1'b1, 2); add(1'b0, GAP_T); add(1'b1, 2); add(1'b0, 3);
        add(1'b1, 2); add(1'b0, GAP_T + 1);
        add(1'b1, LONG_T + 1); add(1'b0, 2);
        run_seg();
        check("boundary_total", press_count, 8'd4);

        do_reset(1'b0, "rst4");
        for (int i = 0; i < 256; i++) begin
            add(1'b1, 2); add(1'b0, GAP_T + 1);
        end
        run_seg();
        check("wrap_total", press_count, 8'd0);

        // abort in the middle of a gap: the pending short press must vanish
        do_reset(1'b0, "rst5");
        add(1'b1, 2); add(1'b0, 2);
        run_seg();
        do_reset(1'b0, "abort_gap");
        add(1'b0, 12);
        run_seg();
        check("abort_total", press_count, 8'd0);

        // abort during a long hold, with the button still down afterwards
        add(1'b1, 12);
        run_seg();
        do_reset(1'b1, "abort_hold");
        add(1'b1, 3); add(1'b0, 8);
        run_seg();

        for (int seg = 0; seg < 4; seg++) begin
            do_reset(1'b0, $sformatf("rnd%0d", seg));
            lim = 300 + int'($urandom_range(0, 100));
            while (ptr < lim) begin
                hi = int'($urandom_range(1, 12));
                lo = int'($urandom_range(1, 7));
                add(1'b1, hi);
                add(1'b0, lo);
            end
            add(1'b0, GAP_T + 2);
            run_seg();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
